// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm -- receive-side UART controller.
//
// Oversamples the serial line, validates the start bit at its centre, then
// captures 5..9 data bits LSB first and checks the stop bit. A completed frame
// is presented on o_data with a one-cycle o_valid pulse and a framing-error
// flag. The word length is latched when the start bit is detected.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   -> each data/stop bit is the 2-of-3 majority of the samples taken
//                at ticks OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1
//   undefined -> single sample at tick OVERSAMPLE-1
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_en           receiver enable (gates start detection only)
//   i_sample_tick  one-cycle pulse at OVERSAMPLE x baud rate
//   i_rx           asynchronous serial input, idle high
//   i_size         word length (uart_5..uart_9)
//   o_data         received word, right-justified, unused upper bits 0
//   o_valid        one-cycle pulse when a frame completes
//   o_frame_err    qualified by o_valid: stop bit sampled low
//   o_busy         high whenever the receiver is not idle
// -----------------------------------------------------------------------------

package types;
  typedef enum logic [2:0] {
    uart_5 = 3'd0,
    uart_6 = 3'd1,
    uart_7 = 3'd2,
    uart_8 = 3'd3,
    uart_9 = 3'd4
  } uart_size;
endpackage

module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic           i_sample_tick,
  input  logic           i_rx,
  input  types::uart_size i_size,
  output logic [8:0]     o_data,
  output logic           o_valid,
  output logic           o_frame_err,
  output logic           o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Highest data bit index for each word length; unknown encodings give 1 bit.
  function automatic logic [3:0] size_to_max(input types::uart_size sz);
    logic [3:0] m;
    case (sz)
      types::uart_5: m = 4'd4;
      types::uart_6: m = 4'd5;
      types::uart_7: m = 4'd6;
      types::uart_8: m = 4'd7;
      types::uart_9: m = 4'd8;
      default:       m = 4'd0;
    endcase
    return m;
  endfunction

  // Two-of-three majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  logic          fall_s;
  logic          bit_s;
  state_t        state_r;
  logic [TW-1:0] tick_r;
  logic [3:0]    index_r;
  logic [3:0]    max_r;
  logic [8:0]    shift_r;

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign fall_s = rx_prev_r & ~rx_sync_r;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] TICK_M3 = TW'(OVERSAMPLE - 3);
  localparam logic [TW-1:0] TICK_M2 = TW'(OVERSAMPLE - 2);

  logic [1:0] hist_r;

  // Capture the two earlier votes of each data/stop bit ([1] oldest).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hist_r <= 2'b11;
    end else if (i_sample_tick && ((state_r == ST_DATA) || (state_r == ST_STOP))) begin
      if (tick_r == TICK_M3) begin
        hist_r[1] <= rx_sync_r;
      end else if (tick_r == TICK_M2) begin
        hist_r[0] <= rx_sync_r;
      end else begin
        hist_r <= hist_r;
      end
    end else begin
      hist_r <= hist_r;
    end
  end

  // Bit decision is the majority of the two stored votes and the current one.
  always_comb begin
    bit_s = maj3(hist_r[1], hist_r[0], rx_sync_r);
  end
`else
  // Bit decision is the single centre sample.
  always_comb begin
    bit_s = rx_sync_r;
  end
`endif

  // Receive state machine with registered outputs; tick counter clears on
  // every state change so each phase measures from its own entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      tick_r      <= '0;
      index_r     <= 4'd0;
      max_r       <= 4'd0;
      shift_r     <= 9'd0;
      o_data      <= 9'd0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tick_r <= '0;
          // Only an edge starts a frame, so a line held low is ignored.
          if (fall_s && i_en) begin
            state_r <= ST_START;
            o_busy  <= 1'b1;
            shift_r <= 9'd0;
            index_r <= 4'd0;
            max_r   <= size_to_max(i_size);
          end else begin
            o_busy <= 1'b0;
          end
        end

        ST_START: begin
          if (i_sample_tick) begin
            if (tick_r == TICK_HALF) begin
              tick_r <= '0;
              if (!rx_sync_r) begin
                state_r <= ST_DATA;
                index_r <= 4'd0;
              end else begin
                // Line back high at mid start bit: treat as a glitch.
                state_r <= ST_IDLE;
                o_busy  <= 1'b0;
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end else begin
            tick_r <= tick_r;
          end
        end

        ST_DATA: begin
          if (i_sample_tick) begin
            if (tick_r == TICK_LAST) begin
              tick_r           <= '0;
              shift_r[index_r] <= bit_s;
              if (index_r == max_r) begin
                state_r <= ST_STOP;
              end else begin
                index_r <= index_r + 4'd1;
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end else begin
            tick_r <= tick_r;
          end
        end

        ST_STOP: begin
          if (i_sample_tick) begin
            if (tick_r == TICK_LAST) begin
              // Deciding at stop-bit centre leaves half a bit to re-arm for
              // a back-to-back start edge.
              tick_r      <= '0;
              state_r     <= ST_IDLE;
              o_busy      <= 1'b0;
              o_valid     <= 1'b1;
              o_data      <= shift_r;
              o_frame_err <= ~bit_s;
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end else begin
            tick_r <= tick_r;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          tick_r  <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
